// File: rtl/trdb_packet_buffer.sv
// Trace packet buffer: the upstream trace debugger cannot be stalled, so its words land in
// a small FIFO. The FIFO drains toward the trace sink over a valid/ready stream. When the
// FIFO is full, whole bursts of words are dropped. Once a slot frees up, a marker word
// carrying the drop count is written in place of the missing words.
module trdb_packet_buffer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter logic [15:0] MARK_TAG = 16'hFADE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [XLEN-1:0]            packet_word_i,
  input  logic                       packet_word_valid_i,
  input  logic                       flush_i,
  output logic [XLEN-1:0]            data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_e;

  state_e            state_reg, state_next;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              overflow_reg, overflow_next;
  logic [15:0]       drop_cnt_reg, drop_cnt_next;
  logic [XLEN-1:0]   mem_reg [DEPTH];

  logic              full, empty, pop;
  logic              push_en;
  logic [XLEN-1:0]   push_data;
  logic [15:0]       drop_cnt_inc;
  logic [15:0]       drop_cnt_seen;

  // Full is judged on the level before the edge. A pop in the same cycle therefore
  // never makes room for a push in that cycle.
  assign full  = (level_reg == DEPTH_L);
  assign empty = (level_reg == '0);
  assign pop   = !empty && ready_i;

  // The drop counter saturates instead of wrapping, so a huge gap never looks small.
  assign drop_cnt_inc  = (drop_cnt_reg == 16'hFFFF) ? drop_cnt_reg : drop_cnt_reg + 16'd1;
  // The count as it stands after this cycle, including any word dropped right now.
  assign drop_cnt_seen = packet_word_valid_i ? drop_cnt_inc : drop_cnt_reg;

  // State register; flush acts exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: enter DROP on the first lost word, leave it once the marker is written.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (packet_word_valid_i && full) state_next = DROP;
      DROP:    if (!full)                       state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output/datapath control: decide what gets written, and update the drop bookkeeping.
  always_comb begin
    push_en       = 1'b0;
    push_data     = packet_word_i;
    drop_cnt_next = drop_cnt_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      RUN: begin
        if (packet_word_valid_i) begin
          if (!full) begin
            push_en = 1'b1;
          end else begin
            drop_cnt_next = 16'd1;
            overflow_next = 1'b1;
          end
        end
      end
      DROP: begin
        // The marker takes the free slot. An incoming word in the same cycle is lost,
        // and it is counted in the marker.
        if (!full) begin
          push_en       = 1'b1;
          push_data     = XLEN'({MARK_TAG, drop_cnt_seen});
          drop_cnt_next = 16'd0;
        end else begin
          drop_cnt_next = drop_cnt_seen;
        end
      end
      default: ;
    endcase
  end

  // Pointers, occupancy and sticky status.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_en, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage array. Stale contents are harmless because the output masks empty reads to zero.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_en) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // First-word-fall-through head.
  assign data_o     = empty ? '0 : mem_reg[rd_ptr_reg];
  assign valid_o    = !empty;
  assign level_o    = level_reg;
  assign overflow_o = overflow_reg;

endmodule
